bs_drvr_if_fifo: RTL



---
 rtl/bs_drvr_if_fifo.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/bs_drvr_if_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bs_drvr_if_fifo
// Purpose  : Per-driver interface buffer between a processing element and the
//            parallel bus arbiter. Holds an independent TX queue (PE writes,
//            arbiter pops) and RX queue (arbiter pushes, PE reads), both
//            first-word-fall-through.
// Ports    : clk, reset                        - clock, sync active-high reset
//            wr_tx, D_wr_tx, full_tx, alm_full_tx
//                                              - PE side of TX queue
//            pndng, pop, D_pop                 - arbiter side of TX queue
//            push, D_push, full_rx, alm_full_rx
//                                              - arbiter side of RX queue
//            pndng_rx, rd_rx, D_rd_rx          - PE side of RX queue
//            ovf_tx_cnt, ovf_rx_cnt            - dropped-write counters
// Options  : BS_DRVR_FIFO_OVRFLW_CNT_EN - when defined, the overflow counters
//            are implemented (16-bit, saturating); otherwise tied to 0.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// bs_drvr_fifo_q : one FWFT queue with registered status flags.
// ----------------------------------------------------------------------------
module bs_drvr_fifo_q #(
    parameter int BITS        = 256,
    parameter int DEPTH       = 16,
    parameter int ALM_FULL_TH = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr,
    input  logic [BITS-1:0] d_wr,
    input  logic            rd,
    output logic            full,
    output logic            alm_full,
    output logic            pndng,
    output logic [BITS-1:0] d_rd
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH  = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_ALM_TH = (AW+1)'(ALM_FULL_TH);

    logic [BITS-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_cnt;
    logic [AW:0]     w_cnt_nxt;
    logic            r_full;
    logic            r_alm_full;
    logic            r_pndng;
    logic            w_wr_acc;
    logic            w_rd_acc;

    // Acceptance uses the registered flags, so a write while full is dropped
    // even when a read frees a slot at the same edge.
    always_comb begin
        w_wr_acc  = wr & ~r_full;
        w_rd_acc  = rd & r_pndng;
        w_cnt_nxt = r_cnt;
        if (w_wr_acc && !w_rd_acc) begin
            w_cnt_nxt = r_cnt + (AW+1)'(1);
        end else if (w_rd_acc && !w_wr_acc) begin
            w_cnt_nxt = r_cnt - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_full     <= 1'b0;
            r_alm_full <= 1'b0;
            r_pndng    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_cnt      <= w_cnt_nxt;
            r_full     <= (w_cnt_nxt == C_DEPTH);
            r_alm_full <= (w_cnt_nxt >= C_ALM_TH);
            r_pndng    <= (w_cnt_nxt != '0);
        end
    end

    // Storage is not reset; stale words are hidden by the pending mask.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_acc) begin
            r_mem[r_wr_ptr] <= d_wr;
        end
    end

    assign full     = r_full;
    assign alm_full = r_alm_full;
    assign pndng    = r_pndng;
    assign d_rd     = r_pndng ? r_mem[r_rd_ptr] : '0;
endmodule

// ----------------------------------------------------------------------------
// bs_drvr_if_fifo : top level, TX + RX queues and overflow counters.
// ----------------------------------------------------------------------------
module bs_drvr_if_fifo #(
    parameter int BITS        = 256,
    parameter int DEPTH       = 16,
    parameter int ALM_FULL_TH = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_tx,
    input  logic [BITS-1:0] D_wr_tx,
    output logic            full_tx,
    output logic            alm_full_tx,
    output logic            pndng,
    input  logic            pop,
    output logic [BITS-1:0] D_pop,
    input  logic            push,
    input  logic [BITS-1:0] D_push,
    output logic            full_rx,
    output logic            alm_full_rx,
    output logic            pndng_rx,
    input  logic            rd_rx,
    output logic [BITS-1:0] D_rd_rx,
    output logic [15:0]     ovf_tx_cnt,
    output logic [15:0]     ovf_rx_cnt
);
    bs_drvr_fifo_q #(
        .BITS(BITS), .DEPTH(DEPTH), .ALM_FULL_TH(ALM_FULL_TH)
    ) u_tx_q (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr_tx),
        .d_wr     (D_wr_tx),
        .rd       (pop),
        .full     (full_tx),
        .alm_full (alm_full_tx),
        .pndng    (pndng),
        .d_rd     (D_pop)
    );

    bs_drvr_fifo_q #(
        .BITS(BITS), .DEPTH(DEPTH), .ALM_FULL_TH(ALM_FULL_TH)
    ) u_rx_q (
        .clk      (clk),
        .reset    (reset),
        .wr       (push),
        .d_wr     (D_push),
        .rd       (rd_rx),
        .full     (full_rx),
        .alm_full (alm_full_rx),
        .pndng    (pndng_rx),
        .d_rd     (D_rd_rx)
    );

`ifdef BS_DRVR_FIFO_OVRFLW_CNT_EN
    logic [15:0] r_ovf_tx_cnt;
    logic [15:0] r_ovf_rx_cnt;

    // A write strobe while the registered full flag is set is exactly a drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf_tx_cnt <= '0;
            r_ovf_rx_cnt <= '0;
        end else begin
            if (wr_tx && full_tx && (r_ovf_tx_cnt != 16'hFFFF)) begin
                r_ovf_tx_cnt <= r_ovf_tx_cnt + 16'd1;
            end
            if (push && full_rx && (r_ovf_rx_cnt != 16'hFFFF)) begin
                r_ovf_rx_cnt <= r_ovf_rx_cnt + 16'd1;
            end
        end
    end

    assign ovf_tx_cnt = r_ovf_tx_cnt;
    assign ovf_rx_cnt = r_ovf_rx_cnt;
`else
    assign ovf_tx_cnt = '0;
    assign ovf_rx_cnt = '0;
`endif
endmodule
`default_nettype wire
